// File: rtl/util_upack2_timestamp_gate.sv
`default_nettype none
// ============================================================================
// Module   : util_upack2_timestamp_gate
// Brief    : Strips a per-frame timestamp word and releases the frame's data
//            blocks once the local DAC sample time reaches that timestamp.
// Revision : 1.0 - initial release
// ============================================================================
module util_upack2_timestamp_gate #(
    parameter  int NUM_OF_CHANNELS     = 4,
    parameter  int SAMPLES_PER_CHANNEL = 1,
    parameter  int SAMPLE_DATA_WIDTH   = 16,
    localparam int BLOCK_WIDTH         = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH
) (
    input  logic                   dac_clk,
    input  logic                   dac_rst,
    input  logic [63:0]            timestamp,
    input  logic [31:0]            timestamp_every,
    input  logic                   s_axis_valid,
    output logic                   s_axis_ready,
    input  logic [BLOCK_WIDTH-1:0] s_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic [BLOCK_WIDTH-1:0] m_axis_data,
    output logic                   waiting,
    output logic                   late,
    output logic                   underflow
);

    generate
        if (BLOCK_WIDTH < 64) begin : g_width_check
            $error("util_upack2_timestamp_gate: block width must be at least 64 bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EXPECT_TS = 2'd0,
        ST_WAIT      = 2'd1,
        ST_STREAM    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [63:0]            r_target;
    logic [31:0]            r_every;
    logic [31:0]            r_cnt;
    logic                   r_live;
    logic                   r_out_valid;
    logic [BLOCK_WIDTH-1:0] r_out_data;
    logic                   r_late;
    logic                   r_underflow;

    logic w_passthru;
    logic w_drainable;
    logic w_ready;
    logic w_accept;
    logic w_capture;
    logic w_load;
    logic w_is_late;
    logic w_last;
    logic w_underflow;

    assign w_passthru  = (r_state == ST_EXPECT_TS) && (timestamp_every == 32'd0);
    assign w_drainable = !r_out_valid || m_axis_ready;
    // r_live holds ready low for the first cycle after reset
    assign s_axis_ready = w_ready && r_live && !dac_rst;
    assign w_accept    = s_axis_valid && s_axis_ready;
    assign w_capture   = w_accept && (r_state == ST_EXPECT_TS) && !w_passthru;
    assign w_load      = w_accept && (w_passthru || (r_state == ST_STREAM));
    assign w_is_late   = s_axis_data[63:0] < timestamp;
    assign w_last      = (r_cnt == (r_every - 32'd1));
    assign w_underflow = (r_state == ST_STREAM) && !r_out_valid && m_axis_ready && !s_axis_valid;

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_EXPECT_TS: begin
                w_ready = w_passthru ? w_drainable : 1'b1;
                if (w_capture) begin
                    w_next_state = w_is_late ? ST_STREAM : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timestamp >= r_target) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_ready = w_drainable;
                if (w_accept && w_last) begin
                    w_next_state = ST_EXPECT_TS;
                end
            end
            default: w_next_state = ST_EXPECT_TS;
        endcase
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            r_state     <= ST_EXPECT_TS;
            r_target    <= 64'd0;
            r_every     <= 32'd0;
            r_cnt       <= 32'd0;
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_late      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_state     <= w_next_state;
            r_late      <= w_capture && w_is_late;
            r_underflow <= w_underflow;
            if (w_capture) begin
                r_target <= s_axis_data[63:0];
                r_every  <= timestamp_every;
            end
            if (w_load && (r_state == ST_STREAM)) begin
                r_cnt <= w_last ? 32'd0 : r_cnt + 32'd1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= s_axis_data;
            end else if (m_axis_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m_axis_valid = r_out_valid;
    assign m_axis_data  = r_out_data;
    assign waiting      = (r_state == ST_WAIT);
    assign late         = r_late;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_util_upack2_timestamp_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_util_upack2_timestamp_gate
// Brief    : Directed bench with a frame-level reference model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_util_upack2_timestamp_gate;

    localparam int W = 64;

    logic         dac_clk         = 1'b0;
    logic         dac_rst         = 1'b1;
    logic [63:0]  timestamp       = 64'd0;
    logic [31:0]  timestamp_every = 32'd0;
    logic         s_axis_valid    = 1'b0;
    logic         s_axis_ready;
    logic [W-1:0] s_axis_data     = '0;
    logic         m_axis_valid;
    logic         m_axis_ready    = 1'b0;
    logic [W-1:0] m_axis_data;
    logic         waiting;
    logic         late;
    logic         underflow;

    util_upack2_timestamp_gate #(
        .NUM_OF_CHANNELS     (4),
        .SAMPLES_PER_CHANNEL (1),
        .SAMPLE_DATA_WIDTH   (16)
    ) dut (
        .dac_clk         (dac_clk),
        .dac_rst         (dac_rst),
        .timestamp       (timestamp),
        .timestamp_every (timestamp_every),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .waiting         (waiting),
        .late            (late),
        .underflow       (underflow)
    );

    always #5 dac_clk = ~dac_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "pending" until its time arrives, then
    // "left" data words remain to be forwarded; left==0 means a timestamp is due.
    bit           chk_on = 1'b0;
    bit           md_live, md_pend, md_ov, md_late, md_uf;
    logic [63:0]  md_tgt;
    int unsigned  md_left;
    logic [W-1:0] md_od;

    logic [W-1:0] exp_q[$];
    logic [63:0]  appear_ts[$];
    int           n_late, n_uf, n_wait, n_out;
    logic [63:0]  last_wait_ts, last_hs_ts;
    bit           prev_v, prev_hs, prev_rst;
    logic [W-1:0] prev_d;
    bit           tog = 1'b0;

    task automatic model_reset();
        md_live = 0; md_pend = 0; md_ov = 0; md_late = 0; md_uf = 0;
        md_tgt  = 64'd0; md_left = 0; md_od = '0;
    endtask

    always @(negedge dac_clk) begin
        bit need_ts, stream, exp_rdy, xfer;
        if (chk_on) begin
            need_ts = !md_pend && (md_left == 0) && (timestamp_every != 32'd0);
            stream  = !md_pend && (md_left != 0);
            exp_rdy = md_live && !dac_rst && (need_ts || (!md_pend && (!md_ov || m_axis_ready)));

            check("s_axis_ready", s_axis_ready, exp_rdy);
            check("m_axis_valid", m_axis_valid, md_ov);
            if (md_ov) check("m_axis_data", m_axis_data, md_od);
            check("waiting", waiting, md_pend);
            check("late", late, md_late);
            check("underflow", underflow, md_uf);
            if (prev_v && !prev_hs && !prev_rst) begin
                check("hold_valid", m_axis_valid, 1);
                check("hold_data", m_axis_data, prev_d);
            end

            if (waiting) begin n_wait++; last_wait_ts = timestamp; end
            if (late) n_late++;
            if (underflow) n_uf++;
            if (m_axis_valid && (!prev_v || prev_hs)) appear_ts.push_back(timestamp);
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_output: got 0x%0h, expected no word (t=%0t)", m_axis_data, $time);
                end else begin
                    check("sb_data", m_axis_data, exp_q.pop_front());
                end
                n_out++;
                last_hs_ts = timestamp;
            end
            prev_v   = m_axis_valid;
            prev_hs  = m_axis_valid && m_axis_ready;
            prev_d   = m_axis_data;
            prev_rst = dac_rst;

            xfer = s_axis_valid && exp_rdy;
            if (dac_rst) begin
                model_reset();
            end else begin
                md_late = xfer && need_ts && (s_axis_data[63:0] < timestamp);
                md_uf   = stream && !md_ov && m_axis_ready && !s_axis_valid;
                if (xfer && !need_ts) begin
                    md_ov = 1; md_od = s_axis_data;
                end else if (m_axis_ready) begin
                    md_ov = 0;
                end
                if (xfer && need_ts) begin
                    md_tgt  = s_axis_data[63:0];
                    md_left = timestamp_every;
                    md_pend = !(s_axis_data[63:0] < timestamp);
                end else if (md_pend && (timestamp >= md_tgt)) begin
                    md_pend = 0;
                end
                if (xfer && stream) md_left--;
                md_live = 1;
            end
        end else if (dac_rst) begin
            model_reset();
            prev_v = 0; prev_hs = 0; prev_rst = 1; prev_d = '0;
            chk_on = 1'b1;
        end
    end

    task automatic step();
        @(posedge dac_clk);
        #1;
        timestamp = timestamp + 64'd1;
        if (tog) m_axis_ready = !m_axis_ready;
    endtask

    task automatic send(input logic [W-1:0] w);
        bit acc;
        acc          = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = w;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge dac_clk);
            acc = s_axis_ready;
            step();
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: word 0x%0h got no ready, expected accept within 200 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        s_axis_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        s_axis_valid = 1'b0;
        dac_rst = 1'b1;
        step();
        dac_rst = 1'b0;
        step();
        step();
    endtask

    task automatic begin_test();
        appear_ts.delete();
        exp_q.delete();
        n_late = 0; n_uf = 0; n_wait = 0; n_out = 0;
        last_wait_ts = 64'd0; last_hs_ts = 64'd0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_s_ready"},  s_axis_ready, 0);
        check({tag, "_m_valid"},  m_axis_valid, 0);
        check({tag, "_m_data"},   m_axis_data, 0);
        check({tag, "_waiting"},  waiting, 0);
        check({tag, "_late"},     late, 0);
        check({tag, "_underflow"}, underflow, 0);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        check_zero_outputs("reset");
        dac_rst = 1'b0;
        step(); step();

        // pass-through: timestamp_every = 0
        timestamp_every = 32'd0; m_axis_ready = 1'b1;
        do_reset();
        begin_test();
        for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
        for (int i = 1; i <= 8; i++) send(W'(i));
        idle(3);
        check("t1_out_count", n_out, 8);
        check("t1_waiting_seen", n_wait, 0);
        check("t1_late_seen", n_late, 0);
        check("t1_appear_count", appear_ts.size(), 8);
        if (appear_ts.size() == 8) check("t1_back_to_back", appear_ts[7] - appear_ts[0], 7);

        // timed release: TS=120 captured at timestamp 100
        timestamp_every = 32'd4;
        do_reset();
        begin_test();
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hDA7A_0000_0000_00D0 + W'(i));
        timestamp = 64'd100;
        send(W'(120));
        for (int i = 0; i < 4; i++) send(64'hDA7A_0000_0000_00D0 + W'(i));
        idle(4);
        check("t2_last_waiting_ts", last_wait_ts, 120);
        check("t2_d0_appear_ts", (appear_ts.size() > 0) ? appear_ts[0] : 64'hFFFF_FFFF_FFFF_FFFF, 122);
        check("t2_d3_handshake_ts", last_hs_ts, 125);
        check("t2_out_count", n_out, 4);
        check("t2_late_seen", n_late, 0);

        // late frame: TS=400 at timestamp 500
        timestamp_every = 32'd3;
        do_reset();
        begin_test();
        for (int i = 0; i < 3; i++) exp_q.push_back(64'h1A7E_0000_0000_0000 + W'(i));
        timestamp = 64'd500;
        send(W'(400));
        for (int i = 0; i < 3; i++) send(64'h1A7E_0000_0000_0000 + W'(i));
        idle(4);
        check("t3_late_count", n_late, 1);
        check("t3_waiting_seen", n_wait, 0);
        check("t3_d0_appear_ts", (appear_ts.size() > 0) ? appear_ts[0] : 64'hFFFF_FFFF_FFFF_FFFF, 502);
        check("t3_out_count", n_out, 3);

        // back-to-back frames with toggling backpressure
        timestamp_every = 32'd2;
        m_axis_ready = 1'b1;
        do_reset();
        begin_test();
        timestamp = 64'd40;
        tog = 1'b1;
        exp_q.push_back(64'hB0); exp_q.push_back(64'hB1);
        exp_q.push_back(64'hB2); exp_q.push_back(64'hB3);
        send(W'(50)); send(64'hB0); send(64'hB1);
        send(W'(60)); send(64'hB2); send(64'hB3);
        idle(6);
        tog = 1'b0; m_axis_ready = 1'b1;
        idle(2);
        check("t4_appear_count", appear_ts.size(), 4);
        if (appear_ts.size() == 4) begin
            check("t4_d0_appear_ts", appear_ts[0], 52);
            check("t4_d2_appear_ts", appear_ts[2], 62);
        end
        check("t4_out_count", n_out, 4);
        check("t4_queue_drained", exp_q.size(), 0);

        // underflow: four idle cycles after D1, the first still holds D1
        timestamp_every = 32'd4;
        m_axis_ready = 1'b1;
        do_reset();
        begin_test();
        timestamp = 64'd10;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hC0 + W'(i));
        send(W'(12)); send(64'hC0); send(64'hC1);
        idle(4);
        send(64'hC2); send(64'hC3);
        send(W'(1000));
        idle(2);
        check("t5_underflow_count", n_uf, 3);
        check("t5_out_count", n_out, 4);
        check("t5_next_is_ts", waiting, 1);

        // reset while waiting
        timestamp_every = 32'd2;
        do_reset();
        begin_test();
        timestamp = 64'd10;
        exp_q.push_back(64'hE0); exp_q.push_back(64'hE1);
        exp_q.push_back(64'hE2); exp_q.push_back(64'hE3);
        send(W'(5)); send(64'hE0); send(64'hE1);
        send(W'(1000));
        idle(3);
        check("t6_waiting_before_reset", waiting, 1);
        dac_rst = 1'b1;
        step();
        dac_rst = 1'b0;
        check_zero_outputs("t6_after_reset");
        step();
        send(W'(5)); send(64'hE2); send(64'hE3);
        idle(4);
        check("t6_out_count", n_out, 4);
        check("t6_late_count", n_late, 2);
        check("t6_queue_drained", exp_q.size(), 0);
        check("t6_not_waiting", waiting, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
